adder_serial_n: RTL
===================

ADDER_SERIAL_N -- requirements
Module: adder_serial_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width; WIDTH SHALL be a multiple of DIGIT_W.
REQ-002 SHALL have parameter DIGIT_W, default 2, bits added per clock (digit width).
REQ-003 SHALL have port in_clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port in_rst_n, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, upstream operands valid.
REQ-006 SHALL have port out_ready, output, 1, block can accept operands.
REQ-007 SHALL have port in_a, input, WIDTH, operand A.
REQ-008 SHALL have port in_b, input, WIDTH, operand B.
REQ-009 SHALL have port in_sub, input, 1, 1 = A - B, 0 = A + B.
REQ-010 SHALL have port in_acc, input, 1, 1 = use the accumulator in place of in_a.
REQ-011 SHALL have port in_clr, input, 1, clear the accumulator.
REQ-012 SHALL have port out_valid, output, 1, result valid.
REQ-013 SHALL have port in_ready, input, 1, downstream accepts result.
REQ-014 SHALL have port out_s, output, WIDTH, sum/difference.
REQ-015 SHALL have port out_co, output, 1, carry out of MSB; in subtract mode 1 = no borrow.
REQ-016 SHALL have port out_ovf, output, 1, two's-complement overflow.

Function
REQ-017 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; N = WIDTH/DIGIT_W.
REQ-018 SHALL assert out_ready only in IDLE; accept occurs when in_valid and out_ready are both high.
REQ-019 On accept SHALL latch A (acc register if in_acc, else in_a), B (~in_b if in_sub, else in_b), and initial carry = in_sub, then enter RUN.
REQ-020 In RUN SHALL add one DIGIT_W-bit digit per cycle, LSB digit first, and carry the intermediate carry in a register.
REQ-021 SHALL enter DONE after exactly N RUN cycles; out_valid SHALL rise N cycles after the accept edge.
REQ-022 In DONE SHALL hold out_s, out_co and out_ovf stable and out_valid high until in_ready is high, then return to IDLE on that edge.
REQ-023 out_ovf SHALL equal carry-into-MSB XOR carry-out-of-MSB; out_co SHALL equal carry-out-of-MSB.
REQ-024 Accumulator (WIDTH bits) SHALL load out_s on the DONE->IDLE handshake edge.
REQ-025 in_clr SHALL be honoured only in IDLE and SHALL zero the accumulator.
REQ-026 If in_clr and an accept with in_acc=1 occur on the same edge, operand A SHALL be 0.
REQ-027 in_valid SHALL be ignored outside IDLE; in_clr SHALL be ignored outside IDLE; inputs need not be held after accept.
REQ-028 out_s, out_co and out_ovf SHALL keep their last result through IDLE and RUN; they SHALL change only on entry to DONE.

Reset
REQ-029 While in_rst_n is low at an edge, FSM SHALL go to IDLE, with out_ready=1, out_valid=0, out_s=0, out_co=0, out_ovf=0, accumulator=0, and digit counter=0.
REQ-030 Reset asserted in RUN or DONE SHALL abort the operation with no accumulator update; no result for the aborted operation SHALL ever appear.

Structure
REQ-031 Package adder_serial_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and a function computing N from WIDTH and DIGIT_W.
REQ-032 SHALL instantiate exactly one sub-module, digit_adder: a combinational DIGIT_W-bit ripple-carry adder with ports a, b, ci and outputs s, co, plus carry into its MSB for overflow.
REQ-033 SHALL implement operand A/B and the result as shift registers shifting DIGIT_W bits per RUN cycle; no WIDTH-bit combinational adder.

Verification (WIDTH=8, DIGIT_W=2 unless stated)
REQ-034 Bench SHALL check 0xFF + 0x01 -> out_s=0x00, co=1, ovf=0, out_valid 4 cycles after accept.
REQ-035 Bench SHALL check 0x7F + 0x01 -> 0x80, co=0, ovf=1.
REQ-036 Bench SHALL check 0x05 - 0x07 -> 0xFE, co=0, ovf=0.
REQ-037 Bench SHALL check 0x80 - 0x01 -> 0x7F, co=1, ovf=1.
REQ-038 Bench SHALL check clr, then three accepts of B=0x03 with in_acc=1, with in_ready low for 3 cycles on the second result -> results 0x03, 0x06, 0x09; out_s held and out_ready=0 while stalled.
REQ-039 Bench SHALL check reset asserted 2 cycles into RUN -> next cycle out_valid=0, out_ready=1, acc=0; a subsequent 0x10+0x20 SHALL give 0x30.
REQ-040 Bench SHALL check WIDTH=4, DIGIT_W=4: 0xF + 0xF -> 0xE, co=1, ovf=0, out_valid 1 cycle after accept.

Source files
------------

// File: rtl/adder_serial_pkg.sv
// Shared types and helpers for the digit-serial adder.
// Digit count N = WIDTH / DIGIT_W sets the number of RUN cycles per operation.
package adder_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int num_digits(input int width, input int digit_w);
    return width / digit_w;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT_W-bit ripple-carry adder; zero latency, no flow control.
// Also exposes the carry into the digit MSB so the top can derive overflow.
module digit_adder #(
  parameter int DIGIT_W = 2
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               ci,
  output logic [DIGIT_W-1:0] s,
  output logic               co,
  output logic               c_msb
);

  logic [DIGIT_W:0] w_c;

  always_comb begin
    w_c    = '0;
    w_c[0] = ci;
    for (int i = 0; i < DIGIT_W; i++) begin
      w_c[i+1] = (a[i] & b[i]) | (a[i] & w_c[i]) | (b[i] & w_c[i]);
    end
  end

  assign s     = a ^ b ^ w_c[DIGIT_W-1:0];
  assign co    = w_c[DIGIT_W];
  assign c_msb = w_c[DIGIT_W-1];

endmodule

// File: rtl/adder_serial_n.sv
// Digit-serial add/sub with accumulator; result valid N = WIDTH/DIGIT_W cycles after accept.
// Accepts only in IDLE; the result is held in DONE until in_ready, so one op is in flight at a time.
module adder_serial_n
  import adder_serial_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DIGIT_W = 2
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_valid,
  output logic             out_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_acc,
  input  logic             in_clr,
  output logic             out_valid,
  input  logic             in_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_co,
  output logic             out_ovf
);

  localparam int            N    = num_digits(WIDTH, DIGIT_W);
  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t         r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] r_acc;
  logic           r_c;
  logic           r_co;
  logic           r_ovf;
  logic [CW-1:0]  r_cnt;

  logic [DIGIT_W-1:0] w_s;
  logic               w_co;
  logic               w_cm;
  logic [WIDTH-1:0]   w_sh_next;

  digit_adder #(
    .DIGIT_W(DIGIT_W)
  ) u_digit (
    .a    (r_a[DIGIT_W-1:0]),
    .b    (r_b[DIGIT_W-1:0]),
    .ci   (r_c),
    .s    (w_s),
    .co   (w_co),
    .c_msb(w_cm)
  );

  // New digit enters at the top so the LSB digit ends up at bit 0 after N shifts.
  generate
    if (N == 1) begin : g_one
      assign w_sh_next = w_s;
    end else begin : g_multi
      assign w_sh_next = {w_s, r_sh[WIDTH-1:DIGIT_W]};
    end
  endgenerate

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sh    <= '0;
      r_s     <= '0;
      r_acc   <= '0;
      r_c     <= 1'b0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_clr) r_acc <= '0;
          if (in_valid) begin
            r_a     <= in_acc ? (in_clr ? '0 : r_acc) : in_a;
            r_b     <= in_sub ? ~in_b : in_b;
            r_c     <= in_sub;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a   <= r_a >> DIGIT_W;
          r_b   <= r_b >> DIGIT_W;
          r_c   <= w_co;
          r_sh  <= w_sh_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_s     <= w_sh_next;
            r_co    <= w_co;
            r_ovf   <= w_cm ^ w_co;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (in_ready) begin
            r_acc   <= r_s;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_ready = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_s     = r_s;
  assign out_co    = r_co;
  assign out_ovf   = r_ovf;

endmodule
